// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the serial link deserializer. The piso transmitter
// uses the same bit-order constants so both ends of the link agree.
package sipo_deser_pkg;

  // Bit-order encoding for the LSB_FIRST parameter on both link ends
  localparam bit ORDER_LSB_FIRST = 1'b1;
  localparam bit ORDER_MSB_FIRST = 1'b0;

  // One-word holding register: EMPTY has nothing to offer, FULL drives pa_valid
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  // Width of a counter that counts 0..width-1 (never narrower than one bit)
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer. Accepts one bit per se_valid strobe,
// assembles WIDTH-bit words and offers each through a one-word valid/ready
// holding register. Words completing while the holder is full and not
// draining are dropped and flagged on the sticky overrun output.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = ORDER_LSB_FIRST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     se_in,
  input  logic                     se_valid,
  input  logic                     sync,
  output logic [WIDTH-1:0]         pa_out,
  output logic                     pa_valid,
  input  logic                     pa_ready,
  output logic                     overrun,
  input  logic                     clr_ovr,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_base;
  logic [WIDTH-1:0] shreg_shift;
  logic             word_done;
  logic             load_word;
  logic             drop_word;
  hold_state_e      hold_state;
  hold_state_e      hold_next;

  // A sync strobe starts from an empty register so the new word is clean;
  // the incoming bit enters from the end dictated by the link bit order
  always_comb begin
    shreg_base  = sync ? '0 : shreg;
    shreg_shift = shreg_base;
    if (LSB_FIRST == ORDER_LSB_FIRST) begin
      shreg_shift = {se_in, shreg_base[WIDTH-1:1]};
    end else begin
      shreg_shift = {shreg_base[WIDTH-2:0], se_in};
    end
  end

  // The bit landing at the last counter position finishes a word; a sync
  // bit is always bit 0 of a new word and so can never finish one
  assign word_done = se_valid && !sync && (bit_cnt == LAST_BIT);

  // Shift register: shifts on each accepted bit, cleared by a lone sync
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (se_valid) begin
      shreg <= shreg_shift;
    end else if (sync) begin
      shreg <= '0;
    end
  end

  // Bit counter is the whole assembly state: counts accepted bits and wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (se_valid) begin
      if (sync) begin
        bit_cnt <= CNT_W'(1);
      end else if (bit_cnt == LAST_BIT) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end else if (sync) begin
      bit_cnt <= '0;
    end
  end

  // Holding register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_state <= HOLD_EMPTY;
    end else begin
      hold_state <= hold_next;
    end
  end

  // Holding register next state: load when free or draining this edge,
  // otherwise drop the finished word; a drain with no new word empties it
  always_comb begin
    hold_next = hold_state;
    load_word = 1'b0;
    drop_word = 1'b0;
    case (hold_state)
      HOLD_EMPTY: begin
        if (word_done) begin
          load_word = 1'b1;
          hold_next = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (word_done) begin
          if (pa_ready) begin
            load_word = 1'b1;
          end else begin
            drop_word = 1'b1;
          end
        end else if (pa_ready) begin
          hold_next = HOLD_EMPTY;
        end
      end
      default: begin
        hold_next = HOLD_EMPTY;
      end
    endcase
  end

  assign pa_valid = (hold_state == HOLD_FULL);

  // Output word captures the completed word including its final bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pa_out <= '0;
    end else if (load_word) begin
      pa_out <= shreg_shift;
    end
  end

  // Sticky overrun flag; a drop on the same edge as a clear keeps it set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop_word) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed testbench for sipo_deser. Two instances share one serial stream:
// dut_lsb uses LSB-first ordering, dut_msb MSB-first (expects bit-reversed words).
module tb_sipo_deser;

  logic       clk;
  logic       rst;
  logic       se_in;
  logic       se_valid;
  logic       sync;
  logic       pa_ready;
  logic       clr_ovr;
  logic [7:0] pa_out_lsb;
  logic       pa_valid_lsb;
  logic       overrun_lsb;
  logic [2:0] bit_cnt_lsb;
  logic [7:0] pa_out_msb;
  logic       pa_valid_msb;
  logic       overrun_msb;
  logic [2:0] bit_cnt_msb;

  int checks = 0;
  int errors = 0;

  sipo_deser #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .se_in(se_in), .se_valid(se_valid), .sync(sync),
    .pa_out(pa_out_lsb), .pa_valid(pa_valid_lsb), .pa_ready(pa_ready),
    .overrun(overrun_lsb), .clr_ovr(clr_ovr), .bit_cnt(bit_cnt_lsb)
  );

  sipo_deser #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .se_in(se_in), .se_valid(se_valid), .sync(sync),
    .pa_out(pa_out_msb), .pa_valid(pa_valid_msb), .pa_ready(pa_ready),
    .overrun(overrun_msb), .clr_ovr(clr_ovr), .bit_cnt(bit_cnt_msb)
  );

  // 10 time-unit free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle with an accepted bit; returns 1 time unit after the sampling edge
  task automatic apply_stimulus(input logic b);
    se_valid = 1'b1;
    se_in    = b;
    @(posedge clk);
    #1;
    se_valid = 1'b0;
    se_in    = 1'b0;
    sync     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] w;
  int         gaps [8];

  initial begin
    rst      = 1'b0;
    se_in    = 1'b0;
    se_valid = 1'b0;
    sync     = 1'b0;
    pa_ready = 1'b0;
    clr_ovr  = 1'b0;

    // ---- reset state ----
    idle_cycles(3);
    check_output("rst_pa_out", 32'(pa_out_lsb), 32'h0);
    check_output("rst_pa_valid", 32'(pa_valid_lsb), 32'h0);
    check_output("rst_overrun", 32'(overrun_lsb), 32'h0);
    check_output("rst_bit_cnt", 32'(bit_cnt_lsb), 32'h0);
    rst = 1'b1;
    idle_cycles(1);
    $display("[TB] reset released");

    // ---- 0xAA with pa_ready=1 ----
    pa_ready = 1'b1;
    w = 8'hAA;
    for (int i = 0; i < 7; i++) apply_stimulus(w[i]);
    check_output("aa_bit_cnt7", 32'(bit_cnt_lsb), 32'd7);
    check_output("aa_valid_before", 32'(pa_valid_lsb), 32'h0);
    apply_stimulus(w[7]);
    check_output("aa_valid", 32'(pa_valid_lsb), 32'h1);
    check_output("aa_pa_out", 32'(pa_out_lsb), 32'hAA);
    check_output("aa_msb_out", 32'(pa_out_msb), 32'h55);
    check_output("aa_bit_cnt_wrap", 32'(bit_cnt_lsb), 32'h0);
    check_output("aa_overrun", 32'(overrun_lsb), 32'h0);
    idle_cycles(1);
    check_output("aa_valid_drop", 32'(pa_valid_lsb), 32'h0);

    // ---- backpressure: 0x3C then 0xF0, second dropped ----
    pa_ready = 1'b0;
    w = 8'h3C;
    for (int i = 0; i < 8; i++) apply_stimulus(w[i]);
    check_output("bp_first_valid", 32'(pa_valid_lsb), 32'h1);
    check_output("bp_first_out", 32'(pa_out_lsb), 32'h3C);
    w = 8'hF0;
    for (int i = 0; i < 7; i++) apply_stimulus(w[i]);
    check_output("bp_no_ovr_yet", 32'(overrun_lsb), 32'h0);
    apply_stimulus(w[7]);
    check_output("bp_hold_out", 32'(pa_out_lsb), 32'h3C);
    check_output("bp_hold_valid", 32'(pa_valid_lsb), 32'h1);
    check_output("bp_overrun", 32'(overrun_lsb), 32'h1);
    idle_cycles(2);
    check_output("bp_overrun_sticky", 32'(overrun_lsb), 32'h1);
    clr_ovr = 1'b1;
    idle_cycles(1);
    clr_ovr = 1'b0;
    check_output("bp_clr_ovr", 32'(overrun_lsb), 32'h0);
    check_output("bp_clr_keeps_valid", 32'(pa_valid_lsb), 32'h1);
    pa_ready = 1'b1;
    idle_cycles(1);
    check_output("bp_drain", 32'(pa_valid_lsb), 32'h0);

    // ---- overrun set and clear on the same edge: set wins ----
    pa_ready = 1'b0;
    w = 8'h01;
    for (int i = 0; i < 8; i++) apply_stimulus(w[i]);
    w = 8'h02;
    for (int i = 0; i < 7; i++) apply_stimulus(w[i]);
    clr_ovr = 1'b1;
    apply_stimulus(w[7]);
    clr_ovr = 1'b0;
    check_output("ovr_set_wins", 32'(overrun_lsb), 32'h1);
    check_output("ovr_hold_out", 32'(pa_out_lsb), 32'h01);
    clr_ovr = 1'b1;
    pa_ready = 1'b1;
    idle_cycles(1);
    clr_ovr = 1'b0;
    check_output("ovr_cleared", 32'(overrun_lsb), 32'h0);
    check_output("ovr_drain", 32'(pa_valid_lsb), 32'h0);

    // ---- back-to-back: 0x0F pending, ready on the edge 0x55 completes ----
    pa_ready = 1'b0;
    w = 8'h0F;
    for (int i = 0; i < 8; i++) apply_stimulus(w[i]);
    check_output("b2b_first_out", 32'(pa_out_lsb), 32'h0F);
    w = 8'h55;
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(w[i]);
      check_output($sformatf("b2b_valid_%0d", i), 32'(pa_valid_lsb), 32'h1);
    end
    pa_ready = 1'b1;
    apply_stimulus(w[7]);
    check_output("b2b_out", 32'(pa_out_lsb), 32'h55);
    check_output("b2b_valid", 32'(pa_valid_lsb), 32'h1);
    check_output("b2b_overrun", 32'(overrun_lsb), 32'h0);
    idle_cycles(1);
    check_output("b2b_drain", 32'(pa_valid_lsb), 32'h0);

    // ---- junk then sync+se_valid with 0x81 ----
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    check_output("sync_junk_cnt", 32'(bit_cnt_lsb), 32'd3);
    w = 8'h81;
    sync = 1'b1;
    apply_stimulus(w[0]);
    check_output("sync_cnt1", 32'(bit_cnt_lsb), 32'd1);
    check_output("sync_no_valid", 32'(pa_valid_lsb), 32'h0);
    for (int i = 1; i < 8; i++) apply_stimulus(w[i]);
    check_output("sync_out", 32'(pa_out_lsb), 32'h81);
    check_output("sync_msb_out", 32'(pa_out_msb), 32'h81);
    check_output("sync_valid", 32'(pa_valid_lsb), 32'h1);
    idle_cycles(1);

    // ---- lone sync discards a partial word ----
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    sync = 1'b1;
    idle_cycles(1);
    sync = 1'b0;
    check_output("sync_alone_cnt", 32'(bit_cnt_lsb), 32'd0);

    // ---- gapped strobes: 0xC3 and 0x1E on both bit orders ----
    gaps = '{0, 3, 1, 5, 2, 0, 4, 1};
    w = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      idle_cycles(gaps[i]);
      apply_stimulus(w[i]);
    end
    check_output("gap_c3_lsb", 32'(pa_out_lsb), 32'hC3);
    check_output("gap_c3_msb", 32'(pa_out_msb), 32'hC3);
    check_output("gap_c3_valid", 32'(pa_valid_msb), 32'h1);
    idle_cycles(1);
    w = 8'h1E;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(w[i]);
      idle_cycles(gaps[7 - i]);
      if (i == 3) check_output("gap_cnt_hold", 32'(bit_cnt_lsb), 32'd4);
    end
    check_output("gap_1e_lsb", 32'(pa_out_lsb), 32'h1E);
    check_output("gap_1e_msb", 32'(pa_out_msb), 32'h78);

    // ---- reset mid-word with a pending word, then 0x99 ----
    pa_ready = 1'b0;
    w = 8'h42;
    for (int i = 0; i < 8; i++) apply_stimulus(w[i]);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_output("mid_rst_out", 32'(pa_out_lsb), 32'h0);
    check_output("mid_rst_valid", 32'(pa_valid_lsb), 32'h0);
    check_output("mid_rst_cnt", 32'(bit_cnt_lsb), 32'h0);
    check_output("mid_rst_ovr", 32'(overrun_lsb), 32'h0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(1);
    w = 8'h99;
    for (int i = 0; i < 8; i++) apply_stimulus(w[i]);
    check_output("post_rst_out", 32'(pa_out_lsb), 32'h99);
    check_output("post_rst_msb", 32'(pa_out_msb), 32'h99);
    check_output("post_rst_valid", 32'(pa_valid_lsb), 32'h1);
    check_output("post_rst_ovr", 32'(overrun_lsb), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in parallel-out deserializer. It is the receive end of the serial link that the team's parallel-in serial-out shifter drives. It samples one bit per strobe, assembles WIDTH-bit words (LSB-first by default, matching the transmitter), and presents each word on a valid/ready output with a one-word holding register. It sits between the serial line and the FIFO write side, flagging words lost to backpressure.

Parameters:
WIDTH, 8, word width in bits (minimum 2)
LSB_FIRST, 1, 1 = first received bit lands in pa_out[0]; 0 = first received bit lands in pa_out[WIDTH-1]

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  reset, asynchronous assert, active-low
se_in  input  1  serial data bit, sampled when se_valid=1
se_valid  input  1  bit strobe; one bit accepted per cycle when high
sync  input  1  word-boundary marker; restarts word assembly
pa_out  output  WIDTH  assembled word (holding register)
pa_valid  output  1  pa_out holds an undelivered word
pa_ready  input  1  consumer accepts pa_out when pa_valid & pa_ready at an edge
overrun  output  1  sticky: a completed word was dropped
clr_ovr  input  1  synchronous clear of overrun
bit_cnt  output  $clog2(WIDTH)  number of bits of the current partial word (debug/verify)

Behaviour:
- Reset (rst=0, asynchronous): shift register=0, bit_cnt=0, pa_out=0, pa_valid=0, overrun=0. Reset mid-word discards the partial word. Assembly restarts at bit 0 after release.
- Shift, LSB_FIRST=1: shreg <= {se_in, shreg[WIDTH-1:1]}. LSB_FIRST=0: shreg <= {shreg[WIDTH-2:0], se_in}.
- se_valid=0: no shift and bit_cnt holds. Gaps between bits are legal, of any length.
- Each accepted bit increments bit_cnt. The bit accepted at bit_cnt==WIDTH-1 completes the word, and bit_cnt wraps to 0.
- Completion, when the holding register is free (pa_valid=0, or pa_valid&pa_ready in the same cycle):
  - pa_out <= completed word, which includes the final bit, on the same edge.
  - pa_valid=1 from the following cycle.
  - Latency: last bit sampled -> pa_valid high 1 cycle.
- Completion when the holding register is occupied and not draining:
  - Word dropped; pa_out and pa_valid unchanged.
  - overrun <= 1.
- Handshake: pa_valid stays high and pa_out stays stable until an edge with pa_ready=1. pa_valid falls on that edge unless a new word completes on the same edge. In that case pa_valid stays 1 and pa_out takes the new word (back-to-back delivery, no bubble).
- pa_ready with pa_valid=0: ignored.
- sync=1 and se_valid=1: the partial word is discarded, se_in becomes bit 0 of a new word, and bit_cnt <= 1. For WIDTH bits this is never a completion unless WIDTH=1, which is disallowed.
- sync=1 and se_valid=0: partial word discarded, bit_cnt <= 0.
- sync does not affect the holding register, pa_valid or overrun.
- overrun: set on a dropped word; cleared by clr_ovr=1. If a set and a clear occur in the same cycle, set wins.
- No FSM beyond the two-state holding register (EMPTY/FULL = pa_valid) and the bit counter. The counter is the assembly state.

Decomposition:
- Shared package: the counter width function/constant CNT_W = $clog2(WIDTH) and the LSB_FIRST encoding constants, shared with the piso transmitter so both ends agree on bit order.
- Single module. No sub-module needed; the shift register, counter and holding register are each under 40 lines.

Test Plan:
- Default parameters, pa_ready=1, send 0xAA LSB-first (bits 0,1,0,1,0,1,0,1 on 8 consecutive se_valid cycles) -> pa_out=8'hAA, pa_valid=1 exactly 1 cycle after the 8th bit, drops the next cycle; overrun=0.
- pa_ready=0: send 0x3C then 0xF0 back-to-back -> pa_out stays 8'h3C, pa_valid stays 1, overrun=1 after the 16th bit. clr_ovr pulse -> overrun=0.
- pa_ready=1 asserted on exactly the edge where the second word 0x55 completes (first word 0x0F pending) -> pa_out=8'h55, pa_valid continuously 1, overrun=0.
- Send 3 bits of junk, then sync+se_valid with 0x81 (8 bits starting on the sync cycle) -> pa_out=8'h81; bit_cnt reads 1 after the sync cycle.
- Random gaps of 0-5 cycles between se_valid strobes sending 0xC3; LSB_FIRST=0 instance sending the same bit sequence -> LSB_FIRST=1 gives 8'hC3, LSB_FIRST=0 gives the bit-reversed 8'hC3 (unchanged, palindrome). Repeat with 0x1E -> 8'h1E and 8'h78.
- Assert rst low after 5 bits of a word, release, send 0x99 -> all outputs 0 during reset, then pa_out=8'h99 with no contamination from the aborted word.
